// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: state encoding, opcodes and datapath select encodings
// shared by the multicycle RISC-V controller.
package riscv_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/multicycle_controller_output_decode.sv
// ctrl_output_decode: combinational map from controller state to datapath controls;
// ImmSrc follows the opcode directly.
module ctrl_output_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_ready,
    input  logic [6:0] i_op,
    output logic       o_pc_update,
    output logic       o_branch,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_imm_src
);
    always_comb begin
        o_pc_update  = 1'b0;
        o_branch     = 1'b0;
        o_adr_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RS2;
        o_alu_op     = ALUOP_ADD;
        case (i_state)
            S_FETCH: begin
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_ir_write   = i_ready;
                o_pc_update  = i_ready;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  o_adr_src = 1'b1;
            S_MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                o_pc_update = 1'b1;
            end
            S_ALUWB:    o_reg_write = 1'b1;
            S_BEQ: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_op    = ALUOP_SUB;
                o_branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_imm_src = (i_op == OP_SW)  ? IMM_S :
                       (i_op == OP_BEQ) ? IMM_B :
                       (i_op == OP_JAL) ? IMM_J : IMM_I;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing Fetch/Decode/Execute/Memory/Writeback with a mem_ready handshake.
// Optional memory-wait timeout to HALT when CTRL_TIMEOUT_EN is defined.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);
    state_t r_state, w_next;
    logic   w_ready, w_illegal, w_expire, r_illegal;
    logic   w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write;

    assign w_ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout, w_wait;
    assign w_wait   = r_state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    // Expire on the wait cycle that would bring the count up to the limit.
    assign w_expire = w_wait && !w_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (w_next != r_state || w_ready || !w_wait) ? '0 : r_cnt + 1'b1;
            r_timeout <= r_timeout | w_expire;
        end
    end
    assign mem_timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R_TYPE:    w_next = S_EXECUTER;
                    OP_I_ALU:     w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next    = S_HALT;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       w_next = S_FETCH;
            default:    w_next = S_HALT;
        endcase
        if (w_expire) w_next = S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_illegal;
        end
    end

    ctrl_output_decode u_decode (
        .i_state      (r_state),
        .i_ready      (w_ready),
        .i_op         (op),
        .o_pc_update  (w_pc_update),
        .o_branch     (w_branch),
        .o_adr_src    (AdrSrc),
        .o_mem_write  (w_mem_write),
        .o_ir_write   (w_ir_write),
        .o_reg_write  (w_reg_write),
        .o_result_src (ResultSrc),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_alu_op     (ALUOp),
        .o_imm_src    (ImmSrc)
    );

    // Gate enables with rst_n so an asserting reset cannot leak a write while state settles.
    assign PCWrite    = rst_n & (w_pc_update | (w_branch & Zero));
    assign IRWrite    = rst_n & w_ir_write;
    assign MemWrite   = rst_n & w_mem_write;
    assign RegWrite   = rst_n & w_reg_write;
    assign illegal_op = r_illegal;
    assign state_o    = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scenario tests for the multicycle controller.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, mem_timeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state_o;
    int         checks = 0;
    int         errors = 0;

    multicycle_controller #(.MEM_WAIT(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic z);
        @(negedge clk);
        mem_ready = r;
        Zero = z;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        op = 7'b0000011;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin errors++; $display("FAIL reset_enables: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
        checks++; if ({illegal_op, mem_timeout} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b want 00", {illegal_op, mem_timeout}); end
        checks++; if ({AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc} !== 9'b0_00_10_00_10) begin errors++; $display("FAIL reset_muxes: got %b want 000100010", {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic rs [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        int   es [8] = '{0, 0, 0, 1, 2, 3, 3, 4};
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            step(rs[i], 1'b0);
            checks++; if (state_o !== 4'(es[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
            checks++; if (IRWrite !== (i == 2)) begin errors++; $display("FAIL lw_irwrite[%0d]: got %b want %b", i, IRWrite, i == 2); end
            if (i == 7) begin
                checks++; if ({RegWrite, ResultSrc} !== 3'b1_01) begin errors++; $display("FAIL lw_memwb: got %b want 101", {RegWrite, ResultSrc}); end
            end
        end
    endtask

    task automatic test_sw();
        logic rs [7] = '{1, 0, 0, 0, 0, 0, 1};
        int   es [7] = '{0, 1, 2, 5, 5, 5, 5};
        op = 7'b0100011;
        for (int i = 0; i < 7; i++) begin
            step(rs[i], 1'b0);
            checks++; if (state_o !== 4'(es[i])) begin errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
            if (i == 1) begin
                checks++; if (ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
            end
            if (i >= 3) begin
                checks++; if ({MemWrite, AdrSrc} !== 2'b11) begin errors++; $display("FAIL sw_hold[%0d]: got %b want 11", i, {MemWrite, AdrSrc}); end
            end
        end
        step(1'b0, 1'b0);
        checks++; if ({state_o, MemWrite} !== 5'b0000_0) begin errors++; $display("FAIL sw_done: got %b want 00000", {state_o, MemWrite}); end
    endtask

    task automatic test_beq();
        logic zs [2] = '{1, 0};
        op = 7'b1100011;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, zs[k]);
            checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL beq_fetch[%0d]: got %0d want 0", k, state_o); end
            step(1'b1, zs[k]);
            checks++; if ({state_o, ImmSrc} !== {4'd1, 2'b10}) begin errors++; $display("FAIL beq_decode[%0d]: got %b want 000110", k, {state_o, ImmSrc}); end
            step(1'b1, zs[k]);
            checks++; if ({state_o, ALUOp} !== {4'd10, 2'b01}) begin errors++; $display("FAIL beq_state[%0d]: got %b want 101001", k, {state_o, ALUOp}); end
            checks++; if (PCWrite !== zs[k]) begin errors++; $display("FAIL beq_pcwrite[%0d]: got %b want %b", k, PCWrite, zs[k]); end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111;
        step(1'b1, 1'b0);
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL jal_fetch: got %0d want 0", state_o); end
        step(1'b0, 1'b0);
        checks++; if ({state_o, ImmSrc} !== {4'd1, 2'b11}) begin errors++; $display("FAIL jal_decode: got %b want 000111", {state_o, ImmSrc}); end
        step(1'b0, 1'b0);
        checks++; if ({state_o, PCWrite, ALUSrcB, ALUSrcA} !== {4'd8, 1'b1, 2'b10, 2'b01}) begin errors++; $display("FAIL jal_state: got %b want 100011001", {state_o, PCWrite, ALUSrcB, ALUSrcA}); end
        step(1'b0, 1'b0);
        checks++; if ({state_o, RegWrite, ResultSrc} !== {4'd9, 1'b1, 2'b00}) begin errors++; $display("FAIL jal_aluwb: got %b want 1001100", {state_o, RegWrite, ResultSrc}); end
    endtask

    task automatic test_alu();
        logic [6:0] ops [2] = '{7'b0110011, 7'b0010011};
        logic [1:0] bs  [2] = '{2'b00, 2'b01};
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL alu_decode[%0d]: got %0d want 1", k, state_o); end
            step(1'b0, 1'b0);
            checks++; if ({state_o, ALUSrcA, ALUSrcB, ALUOp} !== {4'(6 + k), 2'b10, bs[k], 2'b10}) begin errors++; $display("FAIL alu_exec[%0d]: got %b want %b", k, {state_o, ALUSrcA, ALUSrcB, ALUOp}, {4'(6 + k), 2'b10, bs[k], 2'b10}); end
            step(1'b0, 1'b0);
            checks++; if ({state_o, RegWrite} !== {4'd9, 1'b1}) begin errors++; $display("FAIL alu_wb[%0d]: got %b want 10011", k, {state_o, RegWrite}); end
        end
    endtask

    task automatic test_timeout();
        op = 7'b0000011;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++; if (state_o !== 4'd2) begin errors++; $display("FAIL to_memadr: got %0d want 2", state_o); end
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            checks++; if ({state_o, mem_timeout} !== {4'd3, 1'b0}) begin errors++; $display("FAIL to_wait[%0d]: got %b want 00110", i, {state_o, mem_timeout}); end
        end
        step(1'b0, 1'b0);
        checks++; if ({state_o, mem_timeout} !== {4'd11, 1'b1}) begin errors++; $display("FAIL to_halt: got %b want 10111", {state_o, mem_timeout}); end
        do_reset();
`else
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            checks++; if ({state_o, mem_timeout} !== {4'd3, 1'b0}) begin errors++; $display("FAIL to_wait[%0d]: got %b want 00110", i, {state_o, mem_timeout}); end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++; if (state_o !== 4'd4) begin errors++; $display("FAIL to_memwb: got %0d want 4", state_o); end
`endif
    endtask

    task automatic test_abort();
        op = 7'b0100011;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++; if ({state_o, MemWrite} !== {4'd5, 1'b1}) begin errors++; $display("FAIL abort_pre: got %b want 01011", {state_o, MemWrite}); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++; if ({state_o, MemWrite, IRWrite, PCWrite} !== {4'd0, 3'b000}) begin errors++; $display("FAIL abort_reset: got %b want 0000000", {state_o, MemWrite, IRWrite, PCWrite}); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        op = 7'b1110011;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++; if ({state_o, illegal_op} !== {4'd1, 1'b0}) begin errors++; $display("FAIL ill_decode: got %b want 00010", {state_o, illegal_op}); end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            checks++; if ({state_o, illegal_op, PCWrite, IRWrite, RegWrite, MemWrite} !== {4'd11, 5'b10000}) begin errors++; $display("FAIL ill_halt[%0d]: got %b want 101110000", i, {state_o, illegal_op, PCWrite, IRWrite, RegWrite, MemWrite}); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({state_o, illegal_op, PCWrite, IRWrite} !== {4'd0, 3'b000}) begin errors++; $display("FAIL ill_reset: got %b want 0000000", {state_o, illegal_op, PCWrite, IRWrite}); end
        checks++; if ({ALUSrcB, ResultSrc, mem_timeout} !== 5'b10_10_0) begin errors++; $display("FAIL ill_reset_mux: got %b want 10100", {ALUSrcB, ResultSrc, mem_timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_alu();
        test_timeout();
        test_abort();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
